pe_chan_in_fifo: RTL
====================

# pe_chan_in_fifo

Receiving end of the PE valid/ready channel, the counterpart to the pass-through output channel. It accepts words from an upstream producer (L2/L3 address and operand streams) into a small FIFO and presents them to the HLS core through the core-side `idat`/`ivld`/`irdy` handshake. This decouples producer backpressure from core stalls and absorbs bursts.

## Interface
- `rscid`, 1: resource ID tag carried for the Catapult netlist; no functional effect.
- `width`, 8: data word width in bits.
- `depth`, 4: FIFO entries. Must be a power of two and at least 2.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-high. Clears all state immediately.
- `dat` input width: upstream data word.
- `vld` input 1: upstream word valid.
- `rdy` output 1: FIFO can accept a word this cycle.
- `idat` output width: head-of-FIFO word presented to the core.
- `ivld` output 1: `idat` is valid.
- `irdy` input 1: core consumes the head word this cycle.
- `count` output clog2(depth)+1: current occupancy, 0..depth.

## Operation
- Push: `vld && rdy` at the clock edge writes `dat` at the write pointer and increments the write pointer modulo `depth`.
- Pop: `ivld && irdy` at the clock edge increments the read pointer modulo `depth`.
- `count` next value:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- `rdy` is registered. Next value is `(count_next != depth)`.
  - `rdy` is never combinationally dependent on `irdy`.
  - A full FIFO does not accept a word in the same cycle as a pop; `rdy` rises the cycle after the pop.
- `ivld` = `(count != 0)`.
- `idat` = `mem[rd_ptr]`.
  - No bypass: a word pushed into an empty FIFO first appears on the core side the next cycle.
- Pointers are clog2(depth) bits and wrap naturally. Full and empty are decided by `count`, never by pointer compare.
- `vld` without `rdy`: upstream must hold `dat`; the FIFO ignores it.
- `irdy` without `ivld`: no effect. Underflow is impossible by construction.
- Reset, including reset asserted mid-transfer:
  - `count`=0, pointers=0, `ivld`=0, `rdy`=0, `idat`=0.
  - Storage contents are don't-care, but `idat` must read 0 while empty after reset.
  - Any in-flight word is discarded.
  - `rdy` goes to 1 on the first rising edge after `rst` deasserts.
- Occupancy states: EMPTY (`count`=0), PARTIAL, FULL (`count`=`depth`).
  - EMPTY→PARTIAL on push; PARTIAL→FULL on push at `depth`−1.
  - FULL→PARTIAL on pop; PARTIAL→EMPTY on pop at 1.
  - Simultaneous push+pop in PARTIAL stays in PARTIAL.

## Timing
- Latency from accepted `vld && rdy` to `ivld`=1 on an empty FIFO: 1 cycle.
- Throughput: 1 word/cycle sustained whenever 0 < `count` < `depth`.
- Full-to-ready recovery: 1 cycle after a pop.
- All outputs except `idat`/`ivld` are flop outputs. `idat`/`ivld` are a mux and compare on flops; there is no input-to-output combinational path.

## Structure
- Shared package `pe_chan_pkg` holds:
  - `clog2` function.
  - Pointer and count width constants derived from `depth`.
  - Reset-value localparams.
- One sub-module, `pe_chan_fifo_mem`: a `depth`×`width` register array.
  - Synchronous write port with write-enable.
  - Asynchronous read port.
  - No reset.
- Top-level holds the pointers, `count`, the `rdy` flop and the handshake logic.

## Test plan
1. Reset release → `rdy`=0, `ivld`=0, `count`=0 while `rst`=1. After the first edge with `rst`=0, `rdy`=1.
2. Push 0xA5 into empty (`irdy`=0) → next cycle `ivld`=1, `idat`=0xA5, `count`=1. Then `irdy`=1 → `ivld`=0 and `count`=0 the following cycle.
3. Push 0x01..0x04 with `irdy`=0, `depth`=4 → `count`=4 and `rdy`=0 after the 4th push. Holding `vld` with 0x05 is not accepted.
4. From full, one pop (`irdy`=1 one cycle) with `vld` held → 0x05 is not taken that cycle. `rdy`=1 next cycle, then 0x05 is accepted. Drain order must be 0x02, 0x03, 0x04, 0x05.
5. Streaming with `vld`=`irdy`=1 for 20 cycles (incrementing data, wrapping pointers) → words out in order, no loss or duplication, `count` stable at 1.
6. Assert `rst` mid-stream with `count`=3 → outputs take reset values immediately (async). After release the old words never appear and the next pushed word 0x7E is the first out.

Source files
------------

// File: rtl/pe_chan_pkg.sv
// Shared definitions for the PE valid/ready channel blocks: width helpers,
// default geometry and reset values.
package pe_chan_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   localparam int def_width = 8;
   localparam int def_depth = 4;
   localparam int def_ptr_w = clog2(def_depth);
   localparam int def_cnt_w = def_ptr_w + 1;

   // Values every channel flop takes while rst is high.
   localparam logic rst_rdy   = 1'b0;
   localparam int   rst_ptr   = 0;
   localparam int   rst_count = 0;

endpackage

// File: rtl/pe_chan_fifo_mem.sv
// depth x width register array: synchronous write, asynchronous read.
module pe_chan_fifo_mem
   import pe_chan_pkg::*;
#(
   parameter int width = def_width,
   parameter int depth = def_depth
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [clog2(depth)-1:0]   waddr,
   input  logic [width-1:0]          wdat,
   input  logic [clog2(depth)-1:0]   raddr,
   output logic [width-1:0]          rdat
);

   logic [width-1:0] mem [depth];

   // NOTE: storage has no reset on purpose; occupancy lives in the control
   // flops, so stale contents are never observed and the array stays plain.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdat;
   end

   assign rdat = mem[raddr];

endmodule

// File: rtl/pe_chan_in_fifo.sv
// Receiving end of the PE valid/ready channel: buffers upstream words in a
// small FIFO and presents them to the core on idat/ivld/irdy.
module pe_chan_in_fifo
   import pe_chan_pkg::*;
#(
   parameter int rscid = 1,
   parameter int width = def_width,
   parameter int depth = def_depth
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [width-1:0]        dat,
   input  logic                    vld,
   output logic                    rdy,
   output logic [width-1:0]        idat,
   output logic                    ivld,
   input  logic                    irdy,
   output logic [clog2(depth):0]   count
);

   localparam int ptr_w = clog2(depth);
   localparam int cnt_w = ptr_w + 1;
   localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic [cnt_w-1:0] count_next;
   logic [width-1:0] head_dat;
   logic             push;
   logic             pop;

   assign push = vld && rdy;
   assign pop  = ivld && irdy;
   assign ivld = (count != '0);

   // Gate the head word so idat reads 0 whenever the FIFO is empty.
   assign idat = ivld ? head_dat : '0;

   // NOTE: every variable driven here gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      count_next = count;
      unique case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= ptr_w'(rst_ptr);
         rd_ptr <= ptr_w'(rst_ptr);
         count  <= cnt_w'(rst_count);
         rdy    <= rst_rdy;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         // Registered: a pop out of FULL re-opens rdy only on the next cycle.
         rdy   <= (count_next != full_cnt);
      end
   end

   pe_chan_fifo_mem #(
      .width (width),
      .depth (depth)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdat  (dat),
      .raddr (rd_ptr),
      .rdat  (head_dat)
   );

endmodule
